// File: rtl/vector_data_cache_pkg.sv
// Shared encodings and helpers for the vector data cache: request/status codes,
// memory handshake codes, FSM states and element bit-position helper.
package vector_data_cache_pkg;

    localparam logic [1:0] D_CACHE_NOP   = 2'd0;
    localparam logic [1:0] D_CACHE_LOAD  = 2'd1;
    localparam logic [1:0] D_CACHE_STORE = 2'd2;

    localparam logic [1:0] D_CACHE_REST    = 2'd0;
    localparam logic [1:0] D_CACHE_WORKING = 2'd1;
    localparam logic [1:0] D_CACHE_STALL   = 2'd2;
    localparam logic [1:0] L_S_FINISHED    = 2'd3;

    localparam logic [1:0] MEM_NOP   = 2'd0;
    localparam logic [1:0] MEM_READ  = 2'd1;
    localparam logic [1:0] MEM_WRITE = 2'd2;

    localparam logic [1:0] MEM_RESTING  = 2'd0;
    localparam logic [1:0] MEM_WORKING  = 2'd1;
    localparam logic [1:0] MEM_FINISHED = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Element 0 lives in the MSBs, so element j starts (n-1-j) elements up.
    function automatic int elem_lsb(input int j, input int n, input int w);
        return (n - 1 - j) * w;
    endfunction

endpackage

// File: rtl/vector_data_cache_line_array.sv
// Tag, per-element valid and data storage for the direct-mapped lines.
// One combinational read port, a full-line write and a single-element write.
module vector_line_array
    import vector_data_cache_pkg::*;
#(
    parameter int ADDR_WIDTH  = 17,
    parameter int LEN         = 32,
    parameter int VECTOR_SIZE = 8,
    parameter int NUM_LINES   = 4,
    parameter int IDX_WIDTH   = 2,
    parameter int SEL_WIDTH   = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [IDX_WIDTH-1:0]       rd_idx,
    output logic [ADDR_WIDTH-1:0]      rd_tag,
    output logic [VECTOR_SIZE-1:0]     rd_valid,
    output logic [LEN*VECTOR_SIZE-1:0] rd_data,
    input  logic                       line_we,
    input  logic [IDX_WIDTH-1:0]       line_idx,
    input  logic [ADDR_WIDTH-1:0]      line_tag,
    input  logic [VECTOR_SIZE-1:0]     line_valid,
    input  logic [LEN*VECTOR_SIZE-1:0] line_data,
    input  logic                       elem_we,
    input  logic [IDX_WIDTH-1:0]       elem_idx,
    input  logic [SEL_WIDTH-1:0]       elem_sel,
    input  logic [LEN-1:0]             elem_data
);

    logic [ADDR_WIDTH-1:0]      tag_r   [NUM_LINES];
    logic [VECTOR_SIZE-1:0]     valid_r [NUM_LINES];
    logic [LEN*VECTOR_SIZE-1:0] data_r  [NUM_LINES];

    assign rd_tag   = tag_r[rd_idx];
    assign rd_valid = valid_r[rd_idx];
    assign rd_data  = data_r[rd_idx];

    // Line storage: cleared on reset, then full-line or single-element updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NUM_LINES; n++) begin
                tag_r[n]   <= '0;
                valid_r[n] <= '0;
                data_r[n]  <= '0;
            end
        end else if (line_we) begin
            tag_r[line_idx]   <= line_tag;
            valid_r[line_idx] <= line_valid;
            data_r[line_idx]  <= line_data;
        end else if (elem_we) begin
            valid_r[elem_idx][elem_sel] <= 1'b1;
            data_r[elem_idx][elem_lsb(int'(elem_sel), VECTOR_SIZE, LEN) +: LEN] <= elem_data;
        end
    end

endmodule

// File: rtl/vector_data_cache.sv
// Direct-mapped, write-through vector data cache: hit/miss/store FSM, element
// counter and memory address generator around the line array.
module vector_data_cache
    import vector_data_cache_pkg::*;
#(
    parameter int ADDR_WIDTH   = 17,
    parameter int LEN          = 32,
    parameter int BYTE_SIZE    = 8,
    parameter int VECTOR_SIZE  = 8,
    parameter int NUM_LINES    = 4,
    parameter int LENGTH_WIDTH = $clog2(VECTOR_SIZE) + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mem_access_enabled,
    input  logic [1:0]                 d_cache_vis_signal,
    input  logic [ADDR_WIDTH-1:0]      data_addr,
    input  logic [LENGTH_WIDTH-1:0]    length,
    input  logic [LEN*VECTOR_SIZE-1:0] writen_vector_data,
    output logic [LEN*VECTOR_SIZE-1:0] vector_data,
    output logic [1:0]                 mem_vis_status,
    input  logic [LEN-1:0]             mem_data,
    input  logic [1:0]                 mem_status,
    output logic [LEN-1:0]             mem_writen_data,
    output logic [ADDR_WIDTH-1:0]      mem_vis_addr,
    output logic [1:0]                 mem_vis_signal
);

    localparam int STRIDE    = LEN / BYTE_SIZE;
    localparam int OFF       = $clog2(VECTOR_SIZE * STRIDE);
    localparam int IDX_WIDTH = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int SEL_WIDTH = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
    localparam int VW        = LEN * VECTOR_SIZE;

    state_t                  state_r, state_n;
    logic [LENGTH_WIDTH-1:0] i_r, i_n, len_r, len_n;
    logic [1:0]              op_r, op_n;
    logic [ADDR_WIDTH-1:0]   start_r, start_n;
    logic [IDX_WIDTH-1:0]    line_idx_r, line_idx_n;
    logic [VW-1:0]           vector_data_r, vector_data_n;
    logic [1:0]              status_r, status_n, mem_sig_r, mem_sig_n;
    logic [ADDR_WIDTH-1:0]   mem_addr_r, mem_addr_n;
    logic [LEN-1:0]          mem_wdata_r, mem_wdata_n;

    logic [IDX_WIDTH-1:0]    idx_s, rd_idx_s;
    logic [ADDR_WIDTH-1:0]   rd_tag_s;
    logic [VECTOR_SIZE-1:0]  rd_valid_s, mask_s, line_valid_s;
    logic [VW-1:0]           rd_data_s, masked_line_s, merged_s, line_data_s;
    logic [LENGTH_WIDTH-1:0] len_eff_s, mask_len_s;
    logic [LEN-1:0]          cur_elem_s;
    logic                    hit_s, line_we_s, elem_we_s;

    if (NUM_LINES > 1) begin : g_idx
        assign idx_s = data_addr[OFF +: IDX_WIDTH];
    end else begin : g_idx_single
        assign idx_s = '0;
    end

    assign len_eff_s  = (length > LENGTH_WIDTH'(VECTOR_SIZE)) ? LENGTH_WIDTH'(VECTOR_SIZE) : length;
    assign rd_idx_s   = (state_r == ST_IDLE) ? idx_s : line_idx_r;
    assign mask_len_s = (state_r == ST_IDLE) ? len_eff_s : len_r;
    assign cur_elem_s = rd_data_s[elem_lsb(int'(i_r[SEL_WIDTH-1:0]), VECTOR_SIZE, LEN) +: LEN];
    assign hit_s      = (rd_tag_s == data_addr) && ((rd_valid_s & mask_s) == mask_s);

    vector_line_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN        (LEN),
        .VECTOR_SIZE(VECTOR_SIZE),
        .NUM_LINES  (NUM_LINES),
        .IDX_WIDTH  (IDX_WIDTH),
        .SEL_WIDTH  (SEL_WIDTH)
    ) u_lines (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (rd_idx_s),
        .rd_tag    (rd_tag_s),
        .rd_valid  (rd_valid_s),
        .rd_data   (rd_data_s),
        .line_we   (line_we_s),
        .line_idx  (idx_s),
        .line_tag  (data_addr),
        .line_valid(line_valid_s),
        .line_data (line_data_s),
        .elem_we   (elem_we_s),
        .elem_idx  (line_idx_r),
        .elem_sel  (i_r[SEL_WIDTH-1:0]),
        .elem_data (mem_data)
    );

    // Element masks: valid-window, zero-padded load result and store merge.
    always_comb begin
        mask_s        = '0;
        masked_line_s = '0;
        merged_s      = '0;
        for (int j = 0; j < VECTOR_SIZE; j++) begin
            if (LENGTH_WIDTH'(j) < mask_len_s) begin
                mask_s[j] = 1'b1;
                masked_line_s[elem_lsb(j, VECTOR_SIZE, LEN) +: LEN] = rd_data_s[elem_lsb(j, VECTOR_SIZE, LEN) +: LEN];
                merged_s[elem_lsb(j, VECTOR_SIZE, LEN) +: LEN] = writen_vector_data[elem_lsb(j, VECTOR_SIZE, LEN) +: LEN];
            end else begin
                merged_s[elem_lsb(j, VECTOR_SIZE, LEN) +: LEN] = rd_data_s[elem_lsb(j, VECTOR_SIZE, LEN) +: LEN];
            end
        end
    end

    // Next-state and registered-output logic of the request FSM.
    always_comb begin
        state_n       = state_r;
        i_n           = i_r;
        len_n         = len_r;
        op_n          = op_r;
        start_n       = start_r;
        line_idx_n    = line_idx_r;
        vector_data_n = vector_data_r;
        status_n      = status_r;
        mem_sig_n     = MEM_NOP;
        mem_addr_n    = mem_addr_r;
        mem_wdata_n   = mem_wdata_r;
        line_we_s     = 1'b0;
        line_valid_s  = '0;
        line_data_s   = rd_data_s;
        elem_we_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!mem_access_enabled) begin
                    status_n = D_CACHE_REST;
                end else if ((len_eff_s == '0) ||
                             ((d_cache_vis_signal != D_CACHE_LOAD) && (d_cache_vis_signal != D_CACHE_STORE))) begin
                    status_n = L_S_FINISHED;
                end else if ((d_cache_vis_signal == D_CACHE_LOAD) && hit_s) begin
                    vector_data_n = masked_line_s;
                    status_n      = L_S_FINISHED;
                end else begin
                    // Miss or store: retag the line before any memory traffic.
                    line_we_s = 1'b1;
                    if (d_cache_vis_signal == D_CACHE_STORE) begin
                        line_data_s  = merged_s;
                        line_valid_s = mask_s;
                    end else begin
                        line_data_s  = rd_data_s;
                        line_valid_s = '0;
                    end
                    op_n       = d_cache_vis_signal;
                    start_n    = data_addr;
                    len_n      = len_eff_s;
                    line_idx_n = idx_s;
                    i_n        = '0;
                    status_n   = D_CACHE_WORKING;
                    state_n    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_status == MEM_WORKING) begin
                    status_n = D_CACHE_STALL;
                end else begin
                    mem_sig_n  = (op_r == D_CACHE_STORE) ? MEM_WRITE : MEM_READ;
                    mem_addr_n = start_r + ADDR_WIDTH'(i_r) * ADDR_WIDTH'(STRIDE);
                    if (op_r == D_CACHE_STORE) begin
                        mem_wdata_n = cur_elem_s;
                    end else begin
                        mem_wdata_n = mem_wdata_r;
                    end
                    status_n = D_CACHE_WORKING;
                    state_n  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_status == MEM_FINISHED) begin
                    elem_we_s = (op_r == D_CACHE_LOAD);
                    i_n       = i_r + LENGTH_WIDTH'(1);
                    if ((i_r + LENGTH_WIDTH'(1)) == len_r) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_ISSUE;
                    end
                end else begin
                    state_n = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (op_r == D_CACHE_LOAD) begin
                    vector_data_n = masked_line_s;
                end else begin
                    vector_data_n = vector_data_r;
                end
                status_n = L_S_FINISHED;
                state_n  = ST_IDLE;
            end
            default: begin
                state_n  = ST_IDLE;
                status_n = D_CACHE_REST;
            end
        endcase
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            i_r           <= '0;
            len_r         <= '0;
            op_r          <= D_CACHE_NOP;
            start_r       <= '0;
            line_idx_r    <= '0;
            vector_data_r <= '0;
            status_r      <= D_CACHE_REST;
            mem_sig_r     <= MEM_NOP;
            mem_addr_r    <= '0;
            mem_wdata_r   <= '0;
        end else begin
            state_r       <= state_n;
            i_r           <= i_n;
            len_r         <= len_n;
            op_r          <= op_n;
            start_r       <= start_n;
            line_idx_r    <= line_idx_n;
            vector_data_r <= vector_data_n;
            status_r      <= status_n;
            mem_sig_r     <= mem_sig_n;
            mem_addr_r    <= mem_addr_n;
            mem_wdata_r   <= mem_wdata_n;
        end
    end

    assign vector_data     = vector_data_r;
    assign mem_vis_status  = status_r;
    assign mem_vis_signal  = mem_sig_r;
    assign mem_vis_addr    = mem_addr_r;
    assign mem_writen_data = mem_wdata_r;

endmodule

// File: tb/tb_vector_data_cache.sv
// Directed bench for vector_data_cache: transaction-level cache/memory model,
// responding memory with access checker, and literal spot checks.
module tb_vector_data_cache;
    import vector_data_cache_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mem_access_enabled;
    logic [1:0]   d_cache_vis_signal;
    logic [16:0]  data_addr;
    logic [3:0]   length;
    logic [255:0] writen_vector_data;
    logic [255:0] vector_data;
    logic [1:0]   mem_vis_status;
    logic [31:0]  mem_data;
    logic [1:0]   mem_status;
    logic [31:0]  mem_writen_data;
    logic [16:0]  mem_vis_addr;
    logic [1:0]   mem_vis_signal;

    vector_data_cache dut (
        .clk(clk), .rst_n(rst_n), .mem_access_enabled(mem_access_enabled),
        .d_cache_vis_signal(d_cache_vis_signal), .data_addr(data_addr), .length(length),
        .writen_vector_data(writen_vector_data), .vector_data(vector_data),
        .mem_vis_status(mem_vis_status), .mem_data(mem_data), .mem_status(mem_status),
        .mem_writen_data(mem_writen_data), .mem_vis_addr(mem_vis_addr),
        .mem_vis_signal(mem_vis_signal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  kind;
        logic [16:0] addr;
        logic [31:0] data;
    } acc_t;

    int           checks = 0;
    int           failures = 0;
    acc_t         exp_q[$];
    logic [16:0]  log_addr[$];
    logic [31:0]  log_data[$];
    logic [31:0]  mem[int];
    logic [16:0]  m_tag[4];
    bit           m_valid[4][8];
    logic [31:0]  m_data[4][8];
    logic [255:0] exp_vd = '0;
    int           mem_k = 1;
    int           busy_cnt = 0;
    int           acc_cnt = 0;
    bit           stall_seen = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] memrd(input logic [16:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return 32'hC0DE0000 | {15'h0, a};
    endfunction

    function automatic logic [16:0] log_a(input int n);
        if (n < log_addr.size()) return log_addr[n];
        return 17'h1FFFF;
    endfunction

    function automatic logic [31:0] log_d(input int n);
        if (n < log_data.size()) return log_data[n];
        return 32'hFFFFFFFF;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 4; n++) begin
            m_tag[n] = 17'h0;
            for (int j = 0; j < 8; j++) m_valid[n][j] = 1'b0;
        end
        exp_vd = '0;
    endtask

    // Transaction-level prediction: expected memory accesses, result and latency.
    task automatic predict(input logic [1:0] op, input logic [16:0] addr, input logic [3:0] len,
                           input logic [255:0] wd, output int L, output bit quick);
        int   idx;
        bit   hit;
        acc_t e;
        L = (len > 4'd8) ? 8 : int'(len);
        idx = int'(addr[6:5]);
        quick = 1'b1;
        if (L == 0 || (op != D_CACHE_LOAD && op != D_CACHE_STORE)) begin
            quick = 1'b1;
        end else if (op == D_CACHE_LOAD) begin
            hit = (m_tag[idx] == addr);
            for (int j = 0; j < L; j++) hit = hit && m_valid[idx][j];
            if (!hit) begin
                quick = 1'b0;
                m_tag[idx] = addr;
                for (int j = 0; j < 8; j++) m_valid[idx][j] = 1'b0;
                for (int j = 0; j < L; j++) begin
                    e.kind = MEM_READ;
                    e.addr = addr + 17'(4 * j);
                    e.data = 32'h0;
                    exp_q.push_back(e);
                    m_data[idx][j]  = memrd(e.addr);
                    m_valid[idx][j] = 1'b1;
                end
            end
            exp_vd = '0;
            for (int j = 0; j < L; j++) exp_vd[(7 - j) * 32 +: 32] = m_data[idx][j];
        end else begin
            quick = 1'b0;
            m_tag[idx] = addr;
            for (int j = 0; j < 8; j++) m_valid[idx][j] = (j < L);
            for (int j = 0; j < L; j++) begin
                m_data[idx][j] = wd[(7 - j) * 32 +: 32];
                e.kind = MEM_WRITE;
                e.addr = addr + 17'(4 * j);
                e.data = wd[(7 - j) * 32 +: 32];
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [16:0] addr, input logic [3:0] len,
                         input logic [255:0] wd);
        log_addr.delete();
        log_data.delete();
        acc_cnt = 0;
        stall_seen = 1'b0;
        d_cache_vis_signal = op;
        data_addr = addr;
        length = len;
        writen_vector_data = wd;
        mem_access_enabled = 1'b1;
    endtask

    task automatic run(input string name, input logic [1:0] op, input logic [16:0] addr,
                       input logic [3:0] len, input logic [255:0] wd, input int k, input int busy);
        int L;
        bit quick;
        int cyc;
        bit done;
        predict(op, addr, len, wd, L, quick);
        mem_k = k;
        busy_cnt = busy;
        drive(op, addr, len, wd);
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 600) begin
            @(posedge clk); #1;
            cyc++;
            if (mem_vis_status == L_S_FINISHED) done = 1'b1;
        end
        mem_access_enabled = 1'b0;
        d_cache_vis_signal = D_CACHE_NOP;
        check({name, ".finished"}, done, 1'b1);
        if (done && busy == 0) check({name, ".latency"}, cyc, quick ? 1 : L * (2 + k) + 2);
        check({name, ".vector_data"}, vector_data, exp_vd);
        check({name, ".pending_accesses"}, exp_q.size(), 0);
        @(posedge clk); #1;
        check({name, ".single_finish"}, mem_vis_status, D_CACHE_REST);
    endtask

    // Memory responder and per-cycle access checker.
    initial begin
        logic [1:0]  prev_sig;
        logic [16:0] raddr;
        bit          pend;
        int          cnt;
        acc_t        e;
        prev_sig = MEM_NOP;
        raddr = '0;
        pend = 1'b0;
        cnt = 0;
        mem_status = MEM_RESTING;
        mem_data = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_vis_status == D_CACHE_STALL) stall_seen = 1'b1;
            if (mem_vis_signal != MEM_NOP) begin
                acc_cnt++;
                log_addr.push_back(mem_vis_addr);
                log_data.push_back(mem_writen_data);
                check("mem_pulse_width", prev_sig, MEM_NOP);
                check("mem_issue_while_busy", mem_status == MEM_WORKING, 1'b0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_access actual=%0h@%0h expected=none", mem_vis_signal, mem_vis_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("mem_kind_addr", {mem_vis_signal, mem_vis_addr}, {e.kind, e.addr});
                    if (e.kind == MEM_WRITE) begin
                        check("mem_wdata", mem_writen_data, e.data);
                        mem[int'(e.addr)] = e.data;
                    end
                end
                pend = 1'b1;
                cnt = mem_k;
                raddr = mem_vis_addr;
            end
            prev_sig = mem_vis_signal;
            if (busy_cnt > 0) begin
                mem_status = MEM_WORKING;
                busy_cnt--;
            end else if (pend && cnt == 0) begin
                mem_status = MEM_FINISHED;
                mem_data = memrd(raddr);
                pend = 1'b0;
            end else begin
                if (pend) cnt--;
                mem_status = MEM_RESTING;
            end
        end
    end

    initial begin
        logic [255:0] none;
        int           guard;
        int           L;
        bit           quick;
        none = '0;
        rst_n = 1'b1;
        mem_access_enabled = 1'b0;
        d_cache_vis_signal = D_CACHE_NOP;
        data_addr = '0;
        length = '0;
        writen_vector_data = '0;
        model_reset();
        for (int j = 0; j < 8; j++) mem[32'h100 + 4 * j] = 32'hA0 + j;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.vector_data", vector_data, 256'h0);
        check("reset.status", mem_vis_status, D_CACHE_REST);
        check("reset.mem_signal", mem_vis_signal, MEM_NOP);
        check("reset.mem_addr", mem_vis_addr, 17'h0);
        check("reset.mem_wdata", mem_writen_data, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        run("cold_load", D_CACHE_LOAD, 17'h100, 4'd8, none, 1, 0);
        check("cold_load.literal", vector_data,
              256'h000000A0_000000A1_000000A2_000000A3_000000A4_000000A5_000000A6_000000A7);
        check("cold_load.last_addr", log_a(7), 17'h0011C);
        run("hit_l4", D_CACHE_LOAD, 17'h100, 4'd4, none, 1, 0);
        check("hit_l4.literal", vector_data,
              256'h000000A0_000000A1_000000A2_000000A3_00000000_00000000_00000000_00000000);
        check("hit_l4.no_access", acc_cnt, 0);
        run("store_l4", D_CACHE_STORE, 17'h100, 4'd4,
            256'h00000011_00000012_00000013_00000014_EEEEEEEE_EEEEEEEE_EEEEEEEE_EEEEEEEE, 1, 0);
        run("load_after_short_store", D_CACHE_LOAD, 17'h100, 4'd8, none, 1, 0);
        check("load_after_short_store.reads", acc_cnt, 8);

        run("store_wt", D_CACHE_STORE, 17'h200, 4'd3,
            256'h00000001_00000002_00000003_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 2, 0);
        check("store_wt.w0", {log_a(0), log_d(0)}, {17'h00200, 32'h1});
        check("store_wt.w2", {log_a(2), log_d(2)}, {17'h00208, 32'h3});
        run("store_hit", D_CACHE_LOAD, 17'h200, 4'd3, none, 1, 0);
        check("store_hit.literal", vector_data,
              256'h00000001_00000002_00000003_00000000_00000000_00000000_00000000_00000000);
        run("store_miss_l4", D_CACHE_LOAD, 17'h200, 4'd4, none, 0, 0);

        run("mem_busy", D_CACHE_LOAD, 17'h040, 4'd2, none, 1, 5);
        check("mem_busy.stall_seen", stall_seen, 1'b1);

        run("conflict_a", D_CACHE_LOAD, 17'h000, 4'd2, none, 1, 0);
        run("conflict_b", D_CACHE_LOAD, 17'h080, 4'd2, none, 1, 0);
        run("conflict_a_again", D_CACHE_LOAD, 17'h000, 4'd2, none, 1, 0);
        check("conflict_a_again.reads", acc_cnt, 2);
        run("len0_load", D_CACHE_LOAD, 17'h000, 4'd0, none, 1, 0);
        run("len0_store", D_CACHE_STORE, 17'h000, 4'd0, {8{32'h5A5A5A5A}}, 1, 0);
        run("nop", D_CACHE_NOP, 17'h000, 4'd8, none, 1, 0);
        run("len15_miss", D_CACHE_LOAD, 17'h100, 4'd15, none, 1, 0);
        check("len15_miss.reads", acc_cnt, 8);
        run("len15_hit", D_CACHE_LOAD, 17'h100, 4'd15, none, 1, 0);
        run("wrap", D_CACHE_LOAD, 17'h1FFFC, 4'd2, none, 1, 0);
        check("wrap.second_addr", log_a(1), 17'h00000);

        predict(D_CACHE_LOAD, 17'h300, 4'd8, none, L, quick);
        mem_k = 3;
        drive(D_CACHE_LOAD, 17'h300, 4'd8, none);
        guard = 0;
        while (acc_cnt < 2 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check("reset_mid.reached_wait", acc_cnt >= 2, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check("reset_mid.vector_data", vector_data, 256'h0);
        check("reset_mid.status", mem_vis_status, D_CACHE_REST);
        check("reset_mid.mem_signal", mem_vis_signal, MEM_NOP);
        check("reset_mid.mem_addr", mem_vis_addr, 17'h0);
        check("reset_mid.mem_wdata", mem_writen_data, 32'h0);
        exp_q.delete();
        model_reset();
        mem_access_enabled = 1'b0;
        d_cache_vis_signal = D_CACHE_NOP;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        run("reload_after_reset", D_CACHE_LOAD, 17'h300, 4'd8, none, 1, 0);
        check("reload_after_reset.reads", acc_cnt, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
